// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcodes, addressing mode, IR field layout and fetch state encoding.
package sisc_pkg;

  localparam logic [3:0] OP_NOOP   = 4'd0;
  localparam logic [3:0] OP_LOD    = 4'd1;
  localparam logic [3:0] OP_STR    = 4'd2;
  localparam logic [3:0] OP_SWP    = 4'd3;
  localparam logic [3:0] OP_BRA    = 4'd4;
  localparam logic [3:0] OP_BRR    = 4'd5;
  localparam logic [3:0] OP_BNE    = 4'd6;
  localparam logic [3:0] OP_BNR    = 4'd7;
  localparam logic [3:0] OP_ALU_OP = 4'd8;
  localparam logic [3:0] OP_HLT    = 4'd15;

  localparam logic [3:0] AM_IMM = 4'd8;

  localparam int IR_W        = 32;
  localparam int FIELD_W     = 4;
  localparam int IMM_W       = 16;
  localparam int IR_OPCODE_LSB = 28;
  localparam int IR_MM_LSB     = 24;
  localparam int IR_RD_LSB     = 20;
  localparam int IR_RS_LSB     = 16;
  localparam int IR_RT_LSB     = 12;
  localparam int IR_IMM_LSB    = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } fetch_state_t;

  function automatic logic [FIELD_W-1:0] ir_field(input logic [IR_W-1:0] ir, input int lsb);
    return ir[lsb +: FIELD_W];
  endfunction

endpackage

// File: rtl/sisc_pc_next.sv
// Combinational next-PC selection: sequential increment, PC-relative branch or absolute branch.
module sisc_pc_next
  import sisc_pkg::*;
#(
  parameter int PC_W = 16
) (
  input  logic [PC_W-1:0]  i_pc,
  input  logic [IMM_W-1:0] i_imm,
  input  logic             i_pc_sel,
  input  logic             i_br_sel,
  output logic [PC_W-1:0]  o_pc_inc,
  output logic [PC_W-1:0]  o_pc_next
);

  logic [PC_W-1:0] w_imm;

  // The immediate is resized to the PC width so relative targets wrap naturally.
  assign w_imm    = PC_W'(i_imm);
  assign o_pc_inc = i_pc + PC_W'(1);

  always_comb begin
    o_pc_next = o_pc_inc;
    if (i_pc_sel) begin
      o_pc_next = i_br_sel ? w_imm : (i_pc + w_imm);
    end
  end

endmodule

// File: rtl/sisc_fetch.sv
// SISC instruction fetch unit: PC/IR registers, handshaked imem read with timeout, IR field decode.
module sisc_fetch
  import sisc_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              fetch_req,
  input  logic              pc_write,
  input  logic              pc_sel,
  input  logic              br_sel,
  output logic              imem_rd,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [IR_W-1:0]   imem_rdata,
  input  logic              imem_rdy,
  output logic [3:0]        opcode,
  output logic [3:0]        mm,
  output logic [3:0]        rd,
  output logic [3:0]        rs,
  output logic [3:0]        rt,
  output logic [IMM_W-1:0]  imm,
  output logic [PC_W-1:0]   pc_out,
  output logic              fetch_done,
  output logic              fetch_err,
  output logic              halted
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  fetch_state_t    r_state, w_state_nxt;
  logic [PC_W-1:0] r_pc, w_pc_nxt;
  logic [IR_W-1:0] r_ir, w_ir_nxt;
  logic            r_imem_rd, w_imem_rd_nxt;
  logic [PC_W-1:0] r_imem_addr, w_imem_addr_nxt;
  logic [7:0]      r_cnt, w_cnt_nxt;
  logic            r_err, w_err_nxt;
  logic            r_halted, w_halted_nxt;
  logic [PC_W-1:0] w_pc_inc, w_pc_branch;

  sisc_pc_next #(.PC_W(PC_W)) u_pc_next (
    .i_pc      (r_pc),
    .i_imm     (r_ir[IR_IMM_LSB +: IMM_W]),
    .i_pc_sel  (pc_sel),
    .i_br_sel  (br_sel),
    .o_pc_inc  (w_pc_inc),
    .o_pc_next (w_pc_branch)
  );

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      r_state     <= ST_IDLE;
      r_pc        <= RESET_PC;
      r_ir        <= '0;
      r_imem_rd   <= 1'b0;
      r_imem_addr <= RESET_PC;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_ir        <= w_ir_nxt;
      r_imem_rd   <= w_imem_rd_nxt;
      r_imem_addr <= w_imem_addr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_err       <= w_err_nxt;
      r_halted    <= w_halted_nxt;
    end
  end

  // A PC write in IDLE takes priority; the control FSM keeps fetch_req high so the fetch uses the new PC.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_ir_nxt        = r_ir;
    w_imem_rd_nxt   = r_imem_rd;
    w_imem_addr_nxt = r_imem_addr;
    w_cnt_nxt       = r_cnt;
    w_err_nxt       = r_err;
    w_halted_nxt    = r_halted;
    case (r_state)
      ST_IDLE: begin
        if (pc_write) begin
          w_pc_nxt = w_pc_branch;
        end else if (fetch_req && !r_halted) begin
          w_state_nxt     = ST_WAIT;
          w_imem_rd_nxt   = 1'b1;
          w_imem_addr_nxt = r_pc;
          w_cnt_nxt       = '0;
        end
      end
      ST_WAIT: begin
        if (imem_rdy) begin
          w_ir_nxt      = imem_rdata;
          w_pc_nxt      = w_pc_inc;
          w_imem_rd_nxt = 1'b0;
          w_state_nxt   = ST_DONE;
          if (ir_field(imem_rdata, IR_OPCODE_LSB) == OP_HLT) begin
            w_halted_nxt = 1'b1;
          end
        end else if (r_cnt == CNT_LAST) begin
          w_err_nxt     = 1'b1;
          w_imem_rd_nxt = 1'b0;
          w_ir_nxt      = '0;
          w_state_nxt   = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign imem_rd    = r_imem_rd;
  assign imem_addr  = r_imem_addr;
  assign opcode     = ir_field(r_ir, IR_OPCODE_LSB);
  assign mm         = ir_field(r_ir, IR_MM_LSB);
  assign rd         = ir_field(r_ir, IR_RD_LSB);
  assign rs         = ir_field(r_ir, IR_RS_LSB);
  assign rt         = ir_field(r_ir, IR_RT_LSB);
  assign imm        = r_ir[IR_IMM_LSB +: IMM_W];
  assign pc_out     = r_pc;
  assign fetch_done = (r_state == ST_DONE);
  assign fetch_err  = r_err;
  assign halted     = r_halted;

endmodule

// File: tb/tb_sisc_fetch.sv
// Self-checking bench for sisc_fetch: scoreboard of expected IR/PC/status per fetch, plus branch/timeout/halt/reset scenarios.
module tb_sisc_fetch;

  localparam int          PC_W     = 16;
  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam int          TIMEOUT  = 15;

  logic        clk = 1'b0;
  logic        rst_f = 1'b0;
  logic        fetch_req = 1'b0;
  logic        pc_write = 1'b0;
  logic        pc_sel = 1'b0;
  logic        br_sel = 1'b0;
  logic        imem_rdy = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic [3:0]  opcode, mm, rd, rs, rt;
  logic [15:0] imm;
  logic [15:0] pc_out;
  logic        fetch_done, fetch_err, halted;

  sisc_fetch #(.PC_W(PC_W), .RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_f(rst_f), .fetch_req(fetch_req), .pc_write(pc_write),
    .pc_sel(pc_sel), .br_sel(br_sel), .imem_rd(imem_rd), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_rdy(imem_rdy), .opcode(opcode), .mm(mm),
    .rd(rd), .rs(rs), .rt(rt), .imm(imm), .pc_out(pc_out), .fetch_done(fetch_done),
    .fetch_err(fetch_err), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  mm;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [15:0] imm;
    logic [15:0] pc;
    logic        err;
    logic        halt;
  } obs_t;

  obs_t        sbQueue[$];
  int          checks = 0;
  int          passed = 0;
  logic [15:0] expPc = RESET_PC;

  function automatic obs_t mkExp(input logic [31:0] ir, input logic [15:0] pc, input logic err, input logic halt);
    obs_t e;
    e.op = ir[31:28]; e.mm = ir[27:24]; e.rd = ir[23:20]; e.rs = ir[19:16];
    e.rt = ir[15:12]; e.imm = ir[15:0]; e.pc = pc; e.err = err; e.halt = halt;
    return e;
  endfunction

  function automatic obs_t sampleDut();
    obs_t o;
    o.op = opcode; o.mm = mm; o.rd = rd; o.rs = rs; o.rt = rt;
    o.imm = imm; o.pc = pc_out; o.err = fetch_err; o.halt = halted;
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raises fetch_req for one sampling edge, answers with rdy after `delay` WAIT cycles (never if negative).
  task automatic run_fetch(input logic [31:0] data, input int delay, output int rdCycles,
                           output logic [15:0] addr0, output bit addrStable, output bit doneSeen,
                           output int edgesToDone);
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    rdCycles = 0; addrStable = 1'b1; doneSeen = 1'b0; edgesToDone = 0;
    addr0 = imem_addr;
    for (int c = 0; c < 40 && !doneSeen; c++) begin
      if (imem_rd) begin
        rdCycles++;
        if (imem_addr !== addr0) addrStable = 1'b0;
      end
      if (c == delay) begin
        imem_rdy = 1'b1;
        imem_rdata = data;
      end
      tick();
      imem_rdy = 1'b0;
      edgesToDone = c + 1;
      if (fetch_done) doneSeen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_f = 1'b0;
    tick(); tick();
    checks++;
    if ({imem_rd, imem_addr, pc_out, opcode, fetch_done, fetch_err, halted} !== {1'b0, RESET_PC, RESET_PC, 4'd0, 3'b000})
      $display("[TB] FAIL reset_held: got rd=%b addr=%h pc=%h op=%h done=%b err=%b halt=%b, want 0/%h/%h/0/0/0/0",
               imem_rd, imem_addr, pc_out, opcode, fetch_done, fetch_err, halted, RESET_PC, RESET_PC);
    else passed++;
    rst_f = 1'b1;
    tick();
    checks++;
    if ({imem_rd, pc_out, fetch_done} !== {1'b0, RESET_PC, 1'b0})
      $display("[TB] FAIL reset_release: got rd=%b pc=%h done=%b, want 0/%h/0", imem_rd, pc_out, fetch_done, RESET_PC);
    else passed++;
    expPc = RESET_PC;
  endtask

  task automatic test_basic_fetch();
    int rdc, edges; logic [15:0] a0; bit stable, done; obs_t got, exp;
    sbQueue.push_back(mkExp(32'h8123_4005, expPc + 16'd1, 1'b0, 1'b0));
    imem_rdy = 1'b1;
    imem_rdata = 32'h8123_4005;
    run_fetch(32'h8123_4005, 0, rdc, a0, stable, done, edges);
    checks++;
    if (a0 !== expPc) $display("[TB] FAIL basic_addr: got %h want %h", a0, expPc); else passed++;
    checks++;
    if (!done || edges != 1) $display("[TB] FAIL basic_latency: done=%b edges=%0d want done=1 edges=1", done, edges); else passed++;
    got = sampleDut(); exp = sbQueue.pop_front();
    checks++;
    if (got !== exp) $display("[TB] FAIL basic_fields: got %h want %h", got, exp); else passed++;
    expPc = expPc + 16'd1;
    tick();
    checks++;
    if (fetch_done !== 1'b0) $display("[TB] FAIL basic_done_pulse: got %b want 0", fetch_done); else passed++;
  endtask

  task automatic test_delayed_rdy();
    int rdc, edges; logic [15:0] a0; bit stable, done; obs_t got, exp;
    sbQueue.push_back(mkExp(32'h2450_0007, expPc + 16'd1, 1'b0, 1'b0));
    run_fetch(32'h2450_0007, 3, rdc, a0, stable, done, edges);
    checks++;
    if (rdc != 4 || !stable || a0 !== expPc)
      $display("[TB] FAIL delay_rd: got rdCycles=%0d stable=%b addr=%h want 4/1/%h", rdc, stable, a0, expPc);
    else passed++;
    got = sampleDut(); exp = sbQueue.pop_front();
    checks++;
    if (!done || edges != 4 || got !== exp)
      $display("[TB] FAIL delay_fields: done=%b edges=%0d got %h want 1/4/%h", done, edges, got, exp);
    else passed++;
    expPc = expPc + 16'd1;
    tick();
  endtask

  task automatic test_branch();
    int rdc, edges; logic [15:0] a0; bit stable, done;
    while (expPc != 16'd5) begin
      pc_write = 1'b1; pc_sel = 1'b0;
      tick();
      expPc = expPc + 16'd1;
    end
    pc_write = 1'b0;
    checks++;
    if (pc_out !== 16'd5) $display("[TB] FAIL pc_increment: got %h want 0005", pc_out); else passed++;
    run_fetch(32'h4000_FFFE, 0, rdc, a0, stable, done, edges);
    tick();
    pc_write = 1'b1; pc_sel = 1'b1; br_sel = 1'b0;
    tick();
    pc_write = 1'b0;
    checks++;
    if (pc_out !== 16'h0004) $display("[TB] FAIL branch_rel: got %h want 0004", pc_out); else passed++;
    run_fetch(32'h4000_0020, 0, rdc, a0, stable, done, edges);
    tick();
    pc_write = 1'b1; pc_sel = 1'b1; br_sel = 1'b1;
    tick();
    checks++;
    if (pc_out !== 16'h0020) $display("[TB] FAIL branch_abs: got %h want 0020", pc_out); else passed++;
    pc_sel = 1'b0; br_sel = 1'b0;
    tick();
    pc_write = 1'b0;
    checks++;
    if (pc_out !== 16'h0021) $display("[TB] FAIL branch_seq: got %h want 0021", pc_out); else passed++;
    fetch_req = 1'b1; pc_write = 1'b1;
    tick();
    pc_write = 1'b0;
    checks++;
    if (imem_rd !== 1'b0 || pc_out !== 16'h0022)
      $display("[TB] FAIL write_priority: got rd=%b pc=%h want 0/0022", imem_rd, pc_out);
    else passed++;
    tick();
    fetch_req = 1'b0;
    checks++;
    if (imem_rd !== 1'b1 || imem_addr !== 16'h0022)
      $display("[TB] FAIL fetch_after_write: got rd=%b addr=%h want 1/0022", imem_rd, imem_addr);
    else passed++;
    imem_rdy = 1'b1; imem_rdata = 32'h1000_0000;
    tick();
    imem_rdy = 1'b0;
    tick();
    expPc = 16'h0023;
  endtask

  task automatic test_timeout();
    int rdc, edges; logic [15:0] a0; bit stable, done; obs_t got, exp;
    sbQueue.push_back(mkExp(32'h0, expPc, 1'b1, 1'b0));
    run_fetch(32'h0, -1, rdc, a0, stable, done, edges);
    checks++;
    if (rdc != TIMEOUT || imem_rd !== 1'b0 || a0 !== expPc)
      $display("[TB] FAIL timeout_rd: got rdCycles=%0d rd=%b addr=%h want %0d/0/%h", rdc, imem_rd, a0, TIMEOUT, expPc);
    else passed++;
    got = sampleDut(); exp = sbQueue.pop_front();
    checks++;
    if (!done || got !== exp) $display("[TB] FAIL timeout_fields: done=%b got %h want 1/%h", done, got, exp); else passed++;
    tick();
    sbQueue.push_back(mkExp(32'h5000_0003, expPc + 16'd1, 1'b1, 1'b0));
    run_fetch(32'h5000_0003, 1, rdc, a0, stable, done, edges);
    got = sampleDut(); exp = sbQueue.pop_front();
    checks++;
    if (!done || got !== exp) $display("[TB] FAIL after_error: done=%b got %h want 1/%h", done, got, exp); else passed++;
    expPc = expPc + 16'd1;
    tick();
  endtask

  task automatic test_halt();
    int rdc, edges, rdSeen; logic [15:0] a0; bit stable, done; obs_t got, exp;
    sbQueue.push_back(mkExp(32'hF000_0000, expPc + 16'd1, 1'b1, 1'b1));
    run_fetch(32'hF000_0000, 0, rdc, a0, stable, done, edges);
    got = sampleDut(); exp = sbQueue.pop_front();
    checks++;
    if (!done || got !== exp) $display("[TB] FAIL halt_load: done=%b got %h want 1/%h", done, got, exp); else passed++;
    expPc = expPc + 16'd1;
    tick();
    fetch_req = 1'b1;
    rdSeen = 0;
    repeat (10) begin
      tick();
      if (imem_rd) rdSeen++;
    end
    fetch_req = 1'b0;
    checks++;
    if (rdSeen != 0) $display("[TB] FAIL halt_blocks_fetch: got %0d rd cycles want 0", rdSeen); else passed++;
    pc_write = 1'b1; pc_sel = 1'b0;
    tick();
    pc_write = 1'b0;
    expPc = expPc + 16'd1;
    checks++;
    if (pc_out !== expPc) $display("[TB] FAIL halt_pc_write: got %h want %h", pc_out, expPc); else passed++;
    rst_f = 1'b0;
    #1;
    checks++;
    if ({halted, fetch_err, pc_out, opcode} !== {1'b0, 1'b0, RESET_PC, 4'd0})
      $display("[TB] FAIL halt_reset: got halt=%b err=%b pc=%h op=%h want 0/0/%h/0", halted, fetch_err, pc_out, opcode, RESET_PC);
    else passed++;
    tick();
    rst_f = 1'b1;
    expPc = RESET_PC;
    tick();
  endtask

  task automatic test_reset_mid_wait();
    int doneCnt;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick(); tick();
    checks++;
    if (imem_rd !== 1'b1) $display("[TB] FAIL midwait_setup: got rd=%b want 1", imem_rd); else passed++;
    rst_f = 1'b0;
    #1;
    checks++;
    if (imem_rd !== 1'b0) $display("[TB] FAIL midwait_async: got rd=%b want 0", imem_rd); else passed++;
    imem_rdy = 1'b1; imem_rdata = 32'h8123_4005;
    tick();
    rst_f = 1'b1;
    doneCnt = 0;
    repeat (3) begin
      tick();
      if (fetch_done) doneCnt++;
    end
    imem_rdy = 1'b0;
    checks++;
    if (opcode !== 4'd0 || doneCnt != 0 || pc_out !== RESET_PC)
      $display("[TB] FAIL midwait_late_rdy: got op=%h done=%0d pc=%h want 0/0/%h", opcode, doneCnt, pc_out, RESET_PC);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_delayed_rdy();
    test_branch();
    test_timeout();
    test_halt();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sisc_fetch.md
Name: sisc_fetch

Overview:
- Instruction-fetch and instruction-register unit for the SISC computer; it is the producer side of the control FSM interface.
- Holds the PC and IR and runs a handshaked read from instruction memory when the control FSM requests a fetch.
- Decodes IR fields (opcode, mm, register fields, immediate) back to the control FSM and datapath.
- Applies branch PC updates commanded by the control FSM via pc_write/pc_sel/br_sel.

Parameters:
PC_W, 16, PC / instruction-address width
RESET_PC, 0, PC value loaded on reset
TIMEOUT, 15, max cycles waiting for imem_rdy before abort (range 1..255)

Ports:
clk  in  1  system clock, rising-edge
rst_f  in  1  reset, asynchronous, active-low
fetch_req  in  1  control FSM fetch request; level, sampled in IDLE only
pc_write  in  1  apply PC update this cycle; sampled in IDLE only
pc_sel  in  1  0: PC <= PC+1; 1: PC <= branch target
br_sel  in  1  branch target select: 0: PC+imm (relative, PC_W-bit wrap); 1: imm[PC_W-1:0] (absolute)
imem_rd  out  1  memory read strobe, held high until imem_rdy
imem_addr  out  PC_W  read address, stable while imem_rd high
imem_rdata  in  32  instruction word, valid when imem_rdy high
imem_rdy  in  1  memory read complete
opcode  out  4  IR[31:28]
mm  out  4  IR[27:24]
rd  out  4  IR[23:20]
rs  out  4  IR[19:16]
rt  out  4  IR[15:12]
imm  out  16  IR[15:0]
pc_out  out  PC_W  current PC
fetch_done  out  1  one-cycle pulse: IR loaded
fetch_err  out  1  sticky: memory timeout occurred
halted  out  1  sticky: HLT (opcode 15) loaded into IR

Behaviour:
- Reset (rst_f low, asynchronous):
  - state=IDLE, PC=RESET_PC, IR=0 (NOOP).
  - imem_rd=0, imem_addr=RESET_PC, fetch_done=0, fetch_err=0, halted=0, timeout counter=0.
- States: IDLE, WAIT, DONE.
- IDLE:
  - pc_write=1 updates PC at the edge.
  - Else if fetch_req=1 and halted=0: go to WAIT, imem_rd<=1, imem_addr<=PC, counter<=0.
  - If pc_write and fetch_req are both 1, pc_write wins; fetch_req must stay high and is taken the next cycle, so the fetch uses the new PC.
- WAIT:
  - imem_rd stays high and imem_addr is stable.
  - imem_rdy=1: IR<=imem_rdata, PC<=PC+1 (wraps at 2^PC_W), imem_rd<=0, go to DONE.
  - imem_rdy=0: counter++. When counter reaches TIMEOUT: fetch_err<=1, imem_rd<=0, IR<=0 (NOOP), PC unchanged, go to DONE.
  - fetch_req and pc_write are ignored in WAIT; pc_write is dropped, not queued.
- DONE:
  - fetch_done=1 for exactly this cycle, then return to IDLE.
  - fetch_req/pc_write are ignored here.
- Latency: fetch_req sampled at edge N -> imem_rd high from N. With rdy seen at edge N+k, fetch_done is high during cycle N+k to N+k+1. Minimum is 2 cycles request-to-done (rdy in the first WAIT cycle).
- Field outputs are driven combinationally from IR and change only when IR loads.
- Branch target:
  - Relative: PC + imm, with imm truncated to PC_W bits; PC is already incremented, so target = fetched-address + 1 + imm.
  - Absolute: imm[PC_W-1:0].
- halted:
  - Set in the same edge IR loads opcode 15; cleared only by reset.
  - A halt fetch still completes (fetch_done pulses); subsequent fetch_req is ignored, while pc_write is still honoured.
- fetch_err is sticky until reset; fetches continue after an error.
- Reset mid-WAIT: imem_rd drops immediately (asynchronous); any later imem_rdy is ignored.

Decomposition:
- Shared package sisc_pkg holds:
  - opcode constants NOOP=0, LOD=1, STR=2, SWP=3, BRA=4, BRR=5, BNE=6, BNR=7, ALU_OP=8, HLT=15
  - the am_imm=8 addressing-mode constant
  - IR field bit positions
  - fetch state encoding
- One natural sub-module: sisc_pc_next, a combinational next-PC mux (PC+1 / PC+imm / imm) selected by pc_sel/br_sel.

Test Plan:
- Reset then fetch_req, imem_rdy same cycle with rdata=32'h8123_4005 -> imem_addr=0, fetch_done pulses 2 cycles after request, opcode=8, mm=1, rd=2, rs=3, imm=16'h4005, pc_out=1.
- Memory delays rdy 3 cycles -> imem_rd high 4 cycles, imem_addr constant=PC, fetch_done 1 cycle after rdy edge, fetch_err=0.
- After fetch at PC=5 with imm=16'hFFFE: pc_write, pc_sel=1, br_sel=0 -> PC=4; br_sel=1 with imm=16'h0020 -> PC=16'h0020; pc_sel=0 -> PC=PC+1.
- imem_rdy never asserted, TIMEOUT=15 -> imem_rd drops after 15 WAIT cycles, fetch_err=1, opcode=0, PC unchanged, fetch_done pulses.
- Load rdata=32'hF000_0000 -> halted=1; next fetch_req gives no imem_rd for 10 cycles; rst_f low -> halted=0, PC=RESET_PC.
- Assert rst_f low two cycles into WAIT -> imem_rd=0 immediately; late imem_rdy does not load IR (opcode stays 0).
